// File: rtl/mem_access_unit.sv
// Load/store unit between the control unit and a word-wide bus with byte enables.
// Performs lane steering, load extension, alignment checks and a bus-abort timeout.
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        re,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic        timeout,
    output logic        bus_req,
    output logic        bus_we,
    output logic [29:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      r_state;
    logic [31:0] r_addr;
    logic [2:0]  r_funct3;
    logic        r_is_load;
    logic [7:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        r_done;
    logic        r_fault;
    logic        r_timeout;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_wdata;

    logic [7:0]  w_cnt_nxt;
    logic        w_illegal;

    function automatic logic f_illegal(input logic rd, input logic wr,
                                       input logic [2:0] f3, input logic [1:0] a);
        logic bad;
        case (f3)
            3'b000:  bad = 1'b0;
            3'b100:  bad = wr;
            3'b001:  bad = a[0];
            3'b101:  bad = wr | a[0];
            3'b010:  bad = |a;
            default: bad = 1'b1;
        endcase
        return bad | (rd & wr);
    endfunction

    function automatic logic [3:0] f_be(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] f_lane_wdata(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    // Shift the addressed lane down to bit 0, then extend according to the access type.
    function automatic logic [31:0] f_load_ext(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> {a, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b100:  return {24'b0, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b101:  return {16'b0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    assign w_cnt_nxt = r_cnt + 8'd1;
    assign w_illegal = f_illegal(re, we, funct3, addr[1:0]);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_funct3    <= '0;
            r_is_load   <= 1'b0;
            r_cnt       <= '0;
            r_rdata     <= '0;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
            r_timeout   <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_be    <= '0;
            r_bus_wdata <= '0;
        end else begin
            r_done    <= 1'b0;
            r_fault   <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (re || we) begin
                        r_addr    <= addr;
                        r_funct3  <= funct3;
                        r_is_load <= re;
                        r_cnt     <= '0;
                        if (w_illegal) begin
                            r_state <= S_ERR;
                            r_fault <= 1'b1;
                        end else begin
                            r_state     <= S_REQ;
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= we;
                            r_bus_be    <= f_be(funct3[1:0], addr[1:0]);
                            r_bus_wdata <= f_lane_wdata(funct3[1:0], wdata);
                        end
                    end
                end
                S_REQ: begin
                    // An ack arriving on the final allowed cycle still wins over the abort.
                    if (bus_ack) begin
                        if (r_is_load) begin
                            r_rdata <= f_load_ext(r_funct3, r_addr[1:0], bus_rdata);
                        end
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_bus_req <= 1'b0;
                        r_bus_we  <= 1'b0;
                        r_bus_be  <= '0;
                    end else if (w_cnt_nxt == TIMEOUT_CNT) begin
                        r_state   <= S_IDLE;
                        r_timeout <= 1'b1;
                        r_bus_req <= 1'b0;
                        r_bus_we  <= 1'b0;
                        r_bus_be  <= '0;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rdata     = r_rdata;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign fault     = r_fault;
    assign timeout   = r_timeout;
    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_addr[31:2];
    assign bus_be    = r_bus_be;
    assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit: the driver pushes model predictions,
// a negedge monitor checks bus fields and pops on every done/fault/timeout pulse.
module tb_mem_access_unit;

    localparam int TO = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        busy, done, fault, timeout;
    logic        bus_req, bus_we;
    logic [29:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .re(re), .we(we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
        .fault(fault), .timeout(timeout), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clock = ~clock;

    // bits = {done, fault, timeout} expected on the response cycle
    typedef struct {
        logic [2:0]  bits;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic        we;
        logic [29:0] baddr;
        logic [31:0] bwdata;
        int          reqcyc;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mon_en = 1'b0;
    logic [31:0] model_rdata = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic r, input logic w, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   input logic [31:0] brd, input int ack_at);
        exp_t   e;
        int     size;
        int     off;
        bit     uns;
        bit     bad;
        longint val;
        uns = f3[2];
        case (f3)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            3'b010:         size = 4;
            default:        size = 0;
        endcase
        e.rdata  = model_rdata;
        e.be     = '0;
        e.we     = w;
        e.baddr  = a[31:2];
        e.bwdata = '0;
        e.reqcyc = 0;
        bad = (size == 0) || (r && w) || (w && uns);
        if (!bad && (a % size) != 0) bad = 1'b1;
        if (bad) begin
            e.bits = 3'b010;
            return e;
        end
        off = int'(a % 4);
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + size) e.be[i] = 1'b1;
            e.bwdata[8*i +: 8] = wd[8*(i % size) +: 8];
        end
        if (ack_at < 1 || ack_at > TO) begin
            e.bits   = 3'b001;
            e.reqcyc = TO;
        end else begin
            e.bits   = 3'b100;
            e.reqcyc = ack_at;
            if (r) begin
                val = (longint'(brd) >> (8 * off)) % (longint'(1) << (8 * size));
                if (!uns && size < 4 && val >= (longint'(1) << (8 * size - 1)))
                    val -= (longint'(1) << (8 * size));
                e.rdata = val[31:0];
            end
        end
        return e;
    endfunction

    // ack_at: bus_req cycle (1-based) on which bus_ack is raised; 0 means never
    task automatic issue(input logic r, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] brd, input int ack_at);
        exp_t e;
        int   reqc;
        bit   fin;
        reqc = 0;
        fin  = 1'b0;
        e = model(r, w, f3, a, wd, brd, ack_at);
        if (e.bits == 3'b100 && r) model_rdata = e.rdata;
        sb.push_back(e);
        @(negedge clock);
        re = r; we = w; funct3 = f3; addr = a; wdata = wd;
        for (int n = 0; n < 400 && !fin; n++) begin
            @(negedge clock);
            if (done || fault || timeout) begin
                re = 1'b0; we = 1'b0; bus_ack = 1'b0; fin = 1'b1;
            end else if (bus_req) begin
                reqc++;
                bus_ack   = (reqc == ack_at);
                bus_rdata = (reqc == ack_at) ? brd : $urandom();
            end else begin
                bus_ack = 1'b0;
            end
        end
        if (!fin) begin
            $display("FAIL txn_hang: got no response expected response within 400 cycles");
            $fatal(1, "transaction did not complete");
        end
    endtask

    always @(negedge clock) begin : monitor
        static int cnt = 0;
        static bit prev_req = 1'b0;
        exp_t e;
        if (mon_en) begin
            if (reset) begin
                cnt = 0;
                prev_req = 1'b0;
            end else begin
                if (bus_req) begin
                    cnt++;
                    chk("busy_in_req", 32'(busy), 32'd1);
                    if (sb.size() > 0) begin
                        chk("bus_addr", 32'(bus_addr), 32'(sb[0].baddr));
                        chk("bus_be", 32'(bus_be), 32'(sb[0].be));
                        chk("bus_we", 32'(bus_we), 32'(sb[0].we));
                        chk("bus_wdata", bus_wdata, sb[0].bwdata);
                    end
                end else begin
                    chk("idle_be", 32'(bus_be), 32'd0);
                end
                if (done || fault || timeout) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_resp: got %b expected none", {done, fault, timeout});
                    end else begin
                        e = sb.pop_front();
                        chk("resp_kind", 32'({done, fault, timeout}), 32'(e.bits));
                        chk("rdata", rdata, e.rdata);
                        chk("req_cycles", cnt, e.reqcyc);
                        if (e.bits != 3'b010) chk("resp_latency", 32'(prev_req), 32'd1);
                    end
                    cnt = 0;
                end
                prev_req = bus_req;
            end
        end
    end

    initial begin
        logic [2:0] legal_f3 [5];
        logic [2:0] f3;
        logic [31:0] a;
        int p, q, ack;
        legal_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        repeat (3) @(negedge clock);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pulses", 32'({done, fault, timeout}), 32'd0);
        chk("rst_bus_req", 32'({bus_req, bus_we}), 32'd0);
        chk("rst_bus_be", 32'(bus_be), 32'd0);
        chk("rst_bus_addr", 32'(bus_addr), 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;

        // LB with lane 3 and a negative byte
        issue(1, 0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 3);
        chk("lb_rdata_const", rdata, 32'hFFFF_FF80);
        // SH to upper half, acked immediately
        issue(0, 1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 1);
        chk("sh_rdata_kept", rdata, 32'hFFFF_FF80);
        // Illegal: misaligned word, then simultaneous load and store
        issue(1, 0, 3'b010, 32'h0000_0006, 32'h0, 32'h0, 1);
        @(negedge clock);
        chk("lw_mis_busy", 32'(busy), 32'd0);
        issue(1, 1, 3'b010, 32'h0000_0010, 32'h0, 32'h0, 1);
        @(negedge clock);
        chk("rw_both_busy", 32'(busy), 32'd0);
        // Timeout, then ack on the very last allowed cycle
        issue(1, 0, 3'b010, 32'h0000_0040, 32'h0, 32'h1111_2222, 0);
        chk("to_rdata_kept", rdata, 32'hFFFF_FF80);
        issue(1, 0, 3'b010, 32'h0000_0044, 32'h0, 32'h1357_9BDF, TO);
        chk("ack_last_rdata", rdata, 32'h1357_9BDF);
        // LHU upper half
        issue(1, 0, 3'b101, 32'h0000_0002, 32'h0, 32'h8001_0000, 2);
        chk("lhu_rdata_const", rdata, 32'h0000_8001);

        // Reset in the middle of a bus request
        @(negedge clock);
        re = 1'b1; funct3 = 3'b010; addr = 32'h0000_0100;
        repeat (3) @(negedge clock);
        chk("pre_rst_req", 32'(bus_req), 32'd1);
        reset = 1'b1; re = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        chk("mid_rst_req", 32'(bus_req), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        model_rdata = '0;
        bus_ack = 1'b1;
        bus_rdata = 32'hDEAD_BEEF;
        repeat (3) begin
            @(negedge clock);
            chk("late_ack_done", 32'({done, busy}), 32'd0);
            chk("late_ack_rdata", rdata, 32'd0);
        end
        bus_ack = 1'b0;

        for (int k = 0; k < 200; k++) begin
            logic rr, ww;
            p = $urandom_range(0, 19);
            rr = (p < 9) || (p >= 18);
            ww = (p >= 9);
            f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                             : legal_f3[$urandom_range(0, 4)];
            a = $urandom();
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            q = $urandom_range(0, 9);
            ack = (q == 0) ? 0 : (q == 1) ? TO : $urandom_range(1, 5);
            issue(rr, ww, f3, a, $urandom(), $urandom(), ack);
        end

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clock);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
